// File: rtl/mtl_pkg.sv
// Shared timing constants and pixel types for the MTL panel renderers.
// The timing controller and the menu/game renderers all import this package.
package mtl_pkg;

    localparam int MTL_H_ACTIVE = 800;
    localparam int MTL_H_FP     = 210;
    localparam int MTL_H_SYNC   = 30;
    localparam int MTL_H_BP     = 16;
    localparam int MTL_V_ACTIVE = 480;
    localparam int MTL_V_FP     = 22;
    localparam int MTL_V_SYNC   = 13;
    localparam int MTL_V_BP     = 10;

    localparam int H_TOTAL = MTL_H_ACTIVE + MTL_H_FP + MTL_H_SYNC + MTL_H_BP;
    localparam int V_TOTAL = MTL_V_ACTIVE + MTL_V_FP + MTL_V_SYNC + MTL_V_BP;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef logic [23:0] rgb_t;

    // Sync flags travel together; both syncs are active-low, so idle is 3'b011.
    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
    } sync_t;

    localparam logic [2:0] SYNC_IDLE = 3'b011;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that lines the {active, hsync_n, vsync_n} flags
// up with pixel data arriving from the free-running pixel source.
module sync_delay
    import mtl_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] din,
    output logic [2:0] dout
);

    logic [2:0] stage_q [DEPTH];
    logic [2:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= SYNC_IDLE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mtl_timing_ctrl.sv
// MTL panel timing generator: free-running h/v counters, sync/active decode,
// and a registered output stage aligned to the externally produced pixel stream.
module mtl_timing_ctrl
    import mtl_pkg::*;
#(
    parameter int H_ACTIVE      = MTL_H_ACTIVE,
    parameter int H_FP          = MTL_H_FP,
    parameter int H_SYNC        = MTL_H_SYNC,
    parameter int H_BP          = MTL_H_BP,
    parameter int V_ACTIVE      = MTL_V_ACTIVE,
    parameter int V_FP          = MTL_V_FP,
    parameter int V_SYNC        = MTL_V_SYNC,
    parameter int V_BP          = MTL_V_BP,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pixel_RGB,
    output logic [10:0] x_cnt,
    output logic [9:0]  y_cnt,
    output logic        frame_start,
    output logic [7:0]  lcd_R,
    output logic [7:0]  lcd_G,
    output logic [7:0]  lcd_B,
    output logic        lcd_DE,
    output logic        lcd_HSD,
    output logic        lcd_VSD
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOT - 1);
    localparam logic [X_W-1:0] H_ACT_END = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_BEGIN  = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END    = X_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOT - 1);
    localparam logic [Y_W-1:0] V_ACT_END = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_BEGIN  = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END    = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0] h_q, h_d;
    logic [Y_W-1:0] v_q, v_d;
    sync_t          raw_sync;
    sync_t          dly_sync;
    logic [2:0]     dly_bits;
    logic           de_q, de_d;
    logic           hsd_q, hsd_d;
    logic           vsd_q, vsd_d;
    rgb_t           rgb_q, rgb_d;

    // The line counter only moves when the pixel counter wraps.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        raw_sync.active  = (h_q < H_ACT_END) && (v_q < V_ACT_END);
        raw_sync.hsync_n = !((h_q >= HS_BEGIN) && (h_q < HS_END));
        raw_sync.vsync_n = !((v_q >= VS_BEGIN) && (v_q < VS_END));
    end

    sync_delay #(
        .DEPTH (PIXEL_LATENCY)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   (raw_sync),
        .dout  (dly_bits)
    );

    assign dly_sync = sync_t'(dly_bits);

    // Colour is blanked outside the visible window so porches and sync stay black.
    always_comb begin
        de_d  = dly_sync.active;
        hsd_d = dly_sync.hsync_n;
        vsd_d = dly_sync.vsync_n;
        rgb_d = dly_sync.active ? pixel_RGB : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            de_q  <= 1'b0;
            hsd_q <= 1'b1;
            vsd_q <= 1'b1;
            rgb_q <= '0;
        end else begin
            de_q  <= de_d;
            hsd_q <= hsd_d;
            vsd_q <= vsd_d;
            rgb_q <= rgb_d;
        end
    end

    assign x_cnt       = h_q;
    assign y_cnt       = v_q;
    assign frame_start = (h_q == '0) && (v_q == '0);
    assign lcd_R       = rgb_q[23:16];
    assign lcd_G       = rgb_q[15:8];
    assign lcd_B       = rgb_q[7:0];
    assign lcd_DE      = de_q;
    assign lcd_HSD     = hsd_q;
    assign lcd_VSD     = vsd_q;

endmodule

// File: tb/tb_mtl_timing_ctrl.sv
// Scoreboard bench for mtl_timing_ctrl, run on a shrunken raster so whole
// frames fit in a short run; one instance at latency 1 and one at latency 3.
module tb_mtl_timing_ctrl;
    import mtl_pkg::*;

    // Small raster: 25 clocks per line, 15 lines per frame, 375 clocks per frame.
    localparam int HA = 16;
    localparam int HFP = 4;
    localparam int HS = 3;
    localparam int HBP = 2;
    localparam int VA = 10;
    localparam int VFP = 2;
    localparam int VS = 2;
    localparam int VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       de;
        logic       hsd;
        logic       vsd;
        logic [23:0] rgb;
    } panel_t;

    localparam panel_t RST_PANEL = '{de: 1'b0, hsd: 1'b1, vsd: 1'b1, rgb: 24'h0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    rgb_t        pix1 = '0;
    rgb_t        pix3 = '0;
    logic [10:0] x1, x3;
    logic [9:0]  y1, y3;
    logic        fs1, fs3;
    logic [7:0]  r1, g1, b1, r3, g3, b3;
    logic        de1, hsd1, vsd1, de3, hsd3, vsd3;

    always #5 clk = ~clk;

    mtl_timing_ctrl #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .PIXEL_LATENCY (1)
    ) dut1 (
        .clk (clk), .reset (reset), .pixel_RGB (pix1),
        .x_cnt (x1), .y_cnt (y1), .frame_start (fs1),
        .lcd_R (r1), .lcd_G (g1), .lcd_B (b1),
        .lcd_DE (de1), .lcd_HSD (hsd1), .lcd_VSD (vsd1)
    );

    mtl_timing_ctrl #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .PIXEL_LATENCY (3)
    ) dut3 (
        .clk (clk), .reset (reset), .pixel_RGB (pix3),
        .x_cnt (x3), .y_cnt (y3), .frame_start (fs3),
        .lcd_R (r3), .lcd_G (g3), .lcd_B (b3),
        .lcd_DE (de3), .lcd_HSD (hsd3), .lcd_VSD (vsd3)
    );

    int      total = 0;
    int      bad = 0;
    int      mh, mv, cyc;
    bit      white = 1'b0;
    panel_t  q1[$];
    panel_t  q3[$];
    rgb_t    hist1[2];
    rgb_t    hist3[4];
    logic    prev_hsd, prev_vsd;
    int      hs_fall0, hs_fall1, hs_width;
    int      vs_fall0, vs_fall1, vs_width;
    int      fs_count, de_count, de3_first;
    rgb_t    de3_first_rgb;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Panel outputs the raster should show for pixel (h, v) fed with colour src.
    function automatic panel_t expect_panel(input int h, input int v, input rgb_t src);
        panel_t p;
        p.de  = (h < HA) && (v < VA);
        p.hsd = !((h >= HA + HFP) && (h < HA + HFP + HS));
        p.vsd = !((v >= VA + VFP) && (v < VA + VFP + VS));
        p.rgb = p.de ? src : 24'h0;
        return p;
    endfunction

    // After reset the first latency+1 output clocks must still be the idle value.
    task automatic init_model();
        mh = 0;
        mv = 0;
        cyc = 0;
        q1.delete();
        q3.delete();
        repeat (2) q1.push_back(RST_PANEL);
        repeat (4) q3.push_back(RST_PANEL);
        for (int i = 0; i < 2; i++) hist1[i] = '0;
        for (int i = 0; i < 4; i++) hist3[i] = '0;
        prev_hsd = 1'b1;
        prev_vsd = 1'b1;
        hs_fall0 = -1; hs_fall1 = -1; hs_width = -1;
        vs_fall0 = -1; vs_fall1 = -1; vs_width = -1;
        fs_count = 0;
        de_count = 0;
        de3_first = -1;
        de3_first_rgb = '0;
    endtask

    // Hold reset for n clocks, checking the idle state each clock, then release.
    task automatic doReset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("rst_x", 32'(x1), 32'd0);
            checkOutput("rst_y", 32'(y1), 32'd0);
            checkOutput("rst_de", 32'(de1), 32'd0);
            checkOutput("rst_hsd", 32'(hsd1), 32'd1);
            checkOutput("rst_vsd", 32'(vsd1), 32'd1);
            checkOutput("rst_rgb", {8'h0, r1, g1, b1}, 32'd0);
            checkOutput("rst_de3", 32'(de3), 32'd0);
        end
        reset = 1'b0;
        init_model();
    endtask

    // One iteration per clock: check counters, push the expectation for the
    // current pixel, pop the one now due at the panel, and feed the sources.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            panel_t e1, e3;
            rgb_t   src;
            checkOutput("x1", 32'(x1), 32'(mh));
            checkOutput("y1", 32'(y1), 32'(mv));
            checkOutput("x3", 32'(x3), 32'(mh));
            checkOutput("y3", 32'(y3), 32'(mv));
            checkOutput("fs1", 32'(fs1), 32'(mh == 0 && mv == 0));
            checkOutput("fs3", 32'(fs3), 32'(mh == 0 && mv == 0));

            src = white ? 24'hFFFFFF : {8'(mh), 8'(mv), 8'hA5};
            q1.push_back(expect_panel(mh, mv, src));
            q3.push_back(expect_panel(mh, mv, src));
            e1 = q1.pop_front();
            e3 = q3.pop_front();
            checkOutput("de1", 32'(de1), 32'(e1.de));
            checkOutput("hsd1", 32'(hsd1), 32'(e1.hsd));
            checkOutput("vsd1", 32'(vsd1), 32'(e1.vsd));
            checkOutput("rgb1", {8'h0, r1, g1, b1}, {8'h0, e1.rgb});
            checkOutput("de3", 32'(de3), 32'(e3.de));
            checkOutput("hsd3", 32'(hsd3), 32'(e3.hsd));
            checkOutput("vsd3", 32'(vsd3), 32'(e3.vsd));
            checkOutput("rgb3", {8'h0, r3, g3, b3}, {8'h0, e3.rgb});

            if (!white && cyc == 9 * HT + 15 + 2) begin
                checkOutput("pix_last_de", 32'(de1), 32'd1);
                checkOutput("pix_last_R", 32'(r1), 32'h0F);
                checkOutput("pix_last_G", 32'(g1), 32'h09);
                checkOutput("pix_last_B", 32'(b1), 32'hA5);
            end
            if (!white && cyc == 9 * HT + 15 + 3) checkOutput("pix_de_fall", 32'(de1), 32'd0);

            if (prev_hsd && !hsd1) begin
                if (hs_fall0 < 0) hs_fall0 = cyc;
                else if (hs_fall1 < 0) hs_fall1 = cyc;
            end
            if (!prev_hsd && hsd1 && hs_width < 0 && hs_fall0 >= 0) hs_width = cyc - hs_fall0;
            if (prev_vsd && !vsd1) begin
                if (vs_fall0 < 0) vs_fall0 = cyc;
                else if (vs_fall1 < 0) vs_fall1 = cyc;
            end
            if (!prev_vsd && vsd1 && vs_width < 0 && vs_fall0 >= 0) vs_width = cyc - vs_fall0;
            if (fs1) fs_count++;
            if (de1) de_count++;
            if (de3 && de3_first < 0) begin
                de3_first = cyc;
                de3_first_rgb = {r3, g3, b3};
            end
            prev_hsd = hsd1;
            prev_vsd = vsd1;

            // Pixel sources answer from the DUT's own coordinates, PIXEL_LATENCY clocks late.
            hist1[1] = hist1[0];
            hist1[0] = white ? 24'hFFFFFF : {x1[7:0], y1[7:0], 8'hA5};
            pix1 = hist1[1];
            for (int i = 3; i > 0; i--) hist3[i] = hist3[i-1];
            hist3[0] = white ? 24'hFFFFFF : {x3[7:0], y3[7:0], 8'hA5};
            pix3 = hist3[3];

            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset release, two whole frames of sync and pixel timing.
        white = 1'b0;
        doReset(3);
        applyStimulus(2 * FRAME);
        checkOutput("hs_first_fall", 32'(hs_fall0), 32'(HA + HFP + 2));
        checkOutput("hs_width", 32'(hs_width), 32'(HS));
        checkOutput("hs_period", 32'(hs_fall1 - hs_fall0), 32'(HT));
        checkOutput("vs_first_fall", 32'(vs_fall0), 32'((VA + VFP) * HT + 2));
        checkOutput("vs_width", 32'(vs_width), 32'(VS * HT));
        checkOutput("vs_period", 32'(vs_fall1 - vs_fall0), 32'(FRAME));
        checkOutput("fs_count", 32'(fs_count), 32'd2);
        checkOutput("lat3_de_rise", 32'(de3_first), 32'd4);
        checkOutput("lat3_first_pix", {8'h0, de3_first_rgb}, 32'h0000A5);

        // Blanking with an all-white source over exactly one frame of output.
        white = 1'b1;
        doReset(2);
        applyStimulus(FRAME + 2);
        checkOutput("de_per_frame", 32'(de_count), 32'(HA * VA));

        // Single-clock reset in the middle of the frame.
        white = 1'b0;
        doReset(2);
        applyStimulus(5 * HT + 8);
        checkOutput("mid_x_before", 32'(x1), 32'd8);
        checkOutput("mid_y_before", 32'(y1), 32'd5);
        doReset(1);
        applyStimulus(3 * HT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
